// File: rtl/score_board.sv
// Purpose : GPR producer scoreboard; tracks where in the pipeline (execute/memory/commit)
//           the youngest producer of each GPR sits so the bypass mux can pick its source.
// Latency : lookup is combinational from registered state; an issue is visible 1 cycle later.
// Backpressure: i_advance=0 freezes all entries and ignores issue; i_flush clears everything.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_advance, i_flush    pipeline move / discard all in-flight producers
//   i_issue_valid/we/dst/load  per-line (0/1) issue information
//   i_src_idx             four source slots (0/1 -> line 0, 2/3 -> line 1)
//   o_score_board_data    per slot one-hot position {ex,mem,commit} and producing line
//   o_load_use_stall      some source depends on a load still in execute

package score_board_pkg;
    typedef struct packed {
        logic [2:0] position;   // [2]=execute, [1]=memory, [0]=commit, 000=register file
        logic       line;
    } score_board_data_t;
endpackage

module score_board
    import score_board_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_advance,
    input  logic                    i_flush,
    input  logic [1:0]              i_issue_valid,
    input  logic [1:0]              i_issue_we,
    input  logic [1:0][4:0]         i_issue_dst,
    input  logic [1:0]              i_issue_load,
    input  logic [3:0][4:0]         i_src_idx,
    output score_board_data_t [3:0] o_score_board_data,
    output logic                    o_load_use_stall
);

    // GPR 0 is hardwired zero and never has a producer, so entries start at 1.
    logic [2:0] r_pos  [1:31];
    logic       r_line [1:31];
    logic       r_load [1:31];

    logic [2:0] w_pos_nxt  [1:31];
    logic       w_line_nxt [1:31];
    logic       w_load_nxt [1:31];

    logic [1:0] w_issue_hit;

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            w_issue_hit[l] = i_issue_valid[l] & i_issue_we[l] & (i_issue_dst[l] != 5'd0);
        end
    end

    always_comb begin
        for (int e = 1; e < 32; e++) begin
            w_pos_nxt[e]  = r_pos[e];
            w_line_nxt[e] = r_line[e];
            w_load_nxt[e] = r_load[e];
            if (i_flush) begin
                w_pos_nxt[e]  = 3'b000;
                w_line_nxt[e] = 1'b0;
                w_load_nxt[e] = 1'b0;
            end else if (i_advance) begin
                // One-hot shift; after any shift the entry has left execute, so the
                // load flag no longer matters and is dropped.
                w_pos_nxt[e]  = r_pos[e] >> 1;
                w_load_nxt[e] = 1'b0;
                // Line 1 is evaluated last so it wins a same-destination collision.
                for (int l = 0; l < 2; l++) begin
                    if (w_issue_hit[l] && (i_issue_dst[l] == 5'(e))) begin
                        w_pos_nxt[e]  = 3'b100;
                        w_line_nxt[e] = l[0];
                        w_load_nxt[e] = i_issue_load[l];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int e = 1; e < 32; e++) begin
                r_pos[e]  <= 3'b000;
                r_line[e] <= 1'b0;
                r_load[e] <= 1'b0;
            end
        end else begin
            for (int e = 1; e < 32; e++) begin
                r_pos[e]  <= w_pos_nxt[e];
                r_line[e] <= w_line_nxt[e];
                r_load[e] <= w_load_nxt[e];
            end
        end
    end

    // Lookup reads registered state only; same-cycle issues are not forwarded here.
    always_comb begin
        o_load_use_stall = 1'b0;
        for (int s = 0; s < 4; s++) begin
            o_score_board_data[s] = '0;
            if (i_src_idx[s] != 5'd0) begin
                o_score_board_data[s].position = r_pos[i_src_idx[s]];
                o_score_board_data[s].line     = r_line[i_src_idx[s]];
                o_load_use_stall = o_load_use_stall
                                 | (r_pos[i_src_idx[s]][2] & r_load[i_src_idx[s]]);
            end
        end
    end

endmodule

// File: tb/tb_score_board.sv
module tb_score_board;
    import score_board_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic                    advance;
    logic                    flush;
    logic [1:0]              issue_valid;
    logic [1:0]              issue_we;
    logic [1:0][4:0]         issue_dst;
    logic [1:0]              issue_load;
    logic [3:0][4:0]         src_idx;
    score_board_data_t [3:0] sb_data;
    logic                    stall;

    score_board dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_advance          (advance),
        .i_flush            (flush),
        .i_issue_valid      (issue_valid),
        .i_issue_we         (issue_we),
        .i_issue_dst        (issue_dst),
        .i_issue_load       (issue_load),
        .i_src_idx          (src_idx),
        .o_score_board_data (sb_data),
        .o_load_use_stall   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endfunction

    // Reference model: each register remembers how many advancing edges have
    // passed since its youngest producer issued (3 or more = retired).
    int age   [32];
    bit mline [32];
    bit mload [32];

    function automatic void model_clear();
        for (int r = 0; r < 32; r++) begin
            age[r] = 3; mline[r] = 1'b0; mload[r] = 1'b0;
        end
    endfunction

    function automatic logic [2:0] pos_of(int a);
        case (a)
            0:       return 3'b100;
            1:       return 3'b010;
            2:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            if (flush) begin
                model_clear();
            end else if (advance) begin
                for (int r = 1; r < 32; r++) if (age[r] < 3) age[r]++;
                for (int l = 0; l < 2; l++) begin
                    if (issue_valid[l] && issue_we[l] && issue_dst[l] != 0) begin
                        age[issue_dst[l]]   = 0;
                        mline[issue_dst[l]] = l[0];
                        mload[issue_dst[l]] = issue_load[l];
                    end
                end
            end
        end
    end

    typedef struct {
        score_board_data_t [3:0] d;
        bit                      st;
    } exp_t;
    exp_t expq[$];

    function automatic exp_t predict();
        exp_t e;
        e.st = 1'b0;
        for (int s = 0; s < 4; s++) begin
            e.d[s] = '0;
            if (src_idx[s] != 0) begin
                e.d[s].position = pos_of(age[src_idx[s]]);
                e.d[s].line     = mline[src_idx[s]];
                if (age[src_idx[s]] == 0 && mload[src_idx[s]]) e.st = 1'b1;
            end
        end
        return e;
    endfunction

    // Monitor: lookup output is presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("lookup_data", 32'(sb_data), 32'(e.d));
            chk("load_use_stall", 32'(stall), 32'(e.st));
        end
    end

    // One cycle: after the edge, drive next issue/control plus lookup sources,
    // then queue the expected lookup result for the monitor.
    task automatic cyc(input bit adv, input bit fl, input bit [1:0] iv, input bit [1:0] we,
                       input bit [1:0] ld, input bit [4:0] d0, input bit [4:0] d1,
                       input bit [4:0] s0, input bit [4:0] s1, input bit [4:0] s2,
                       input bit [4:0] s3);
        @(posedge clk);
        #1;
        advance      = adv;
        flush        = fl;
        issue_valid  = iv;
        issue_we     = we;
        issue_load   = ld;
        issue_dst[0] = d0;
        issue_dst[1] = d1;
        src_idx[0]   = s0;
        src_idx[1]   = s1;
        src_idx[2]   = s2;
        src_idx[3]   = s3;
        expq.push_back(predict());
    endtask

    task automatic look(input bit adv, input bit [4:0] s0, input bit [4:0] s1,
                        input bit [4:0] s2, input bit [4:0] s3);
        cyc(adv, 1'b0, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, s0, s1, s2, s3);
    endtask

    // Spec-derived constant check of one slot, a moment after inputs settle.
    task automatic direct(input string nm, input int slot, input bit [2:0] p,
                          input bit ln, input bit st);
        #1;
        chk({nm, "_pos"},   32'(sb_data[slot].position), 32'(p));
        chk({nm, "_line"},  32'(sb_data[slot].line),     32'(ln));
        chk({nm, "_stall"}, 32'(stall),                  32'(st));
    endtask

    initial begin
        rst_n = 1'b0; advance = 1'b0; flush = 1'b0;
        issue_valid = '0; issue_we = '0; issue_load = '0; issue_dst = '0;
        src_idx = {5'd5, 5'd7, 5'd9, 5'd31};
        model_clear();
        #3;
        chk("reset_data", 32'(sb_data), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Line 0 writes r5: 100 / 010 / 001 / 000 on successive cycles.
        cyc(1, 0, 2'b01, 2'b01, 2'b00, 5'd5, 5'd0, 0, 0, 0, 0);
        look(1, 5, 0, 0, 0); direct("r5_n1", 0, 3'b100, 0, 0);
        look(1, 5, 0, 0, 0); direct("r5_n2", 0, 3'b010, 0, 0);
        look(1, 5, 0, 0, 0); direct("r5_n3", 0, 3'b001, 0, 0);
        look(1, 5, 0, 0, 0); direct("r5_n4", 0, 3'b000, 0, 0);

        // Both lines write r7, line 1 is a load: line 1 wins, stall until it moves on.
        cyc(1, 0, 2'b11, 2'b11, 2'b10, 5'd7, 5'd7, 0, 0, 0, 0);
        look(1, 0, 0, 7, 0); direct("r7_ex", 2, 3'b100, 1, 1);
        look(1, 0, 0, 7, 0); direct("r7_mem", 2, 3'b010, 1, 0);

        // r3 held in execute through three stalled cycles.
        cyc(1, 0, 2'b01, 2'b01, 2'b00, 5'd3, 5'd0, 0, 0, 0, 0);
        look(0, 0, 3, 0, 0); direct("r3_s0", 1, 3'b100, 0, 0);
        look(0, 0, 3, 0, 0); direct("r3_s1", 1, 3'b100, 0, 0);
        look(0, 0, 3, 0, 0); direct("r3_s2", 1, 3'b100, 0, 0);
        look(1, 0, 3, 0, 0); direct("r3_s3", 1, 3'b100, 0, 0);
        look(1, 0, 3, 0, 0); direct("r3_adv", 1, 3'b010, 0, 0);

        // Reissue of r9 on line 1 overwrites the older producer.
        cyc(1, 0, 2'b01, 2'b01, 2'b00, 5'd9, 5'd0, 0, 0, 0, 0);
        cyc(1, 0, 2'b10, 2'b10, 2'b00, 5'd0, 5'd9, 0, 0, 0, 0);
        look(1, 0, 0, 0, 9); direct("r9_young", 3, 3'b100, 1, 0);

        // Flush with a concurrent issue to r4 leaves nothing in flight.
        cyc(1, 0, 2'b01, 2'b01, 2'b00, 5'd10, 5'd0, 0, 0, 0, 0);
        cyc(1, 0, 2'b01, 2'b01, 2'b00, 5'd11, 5'd0, 0, 0, 0, 0);
        cyc(1, 0, 2'b01, 2'b01, 2'b01, 5'd12, 5'd0, 0, 0, 0, 0);
        cyc(1, 1, 2'b01, 2'b01, 2'b00, 5'd4, 5'd0, 10, 11, 12, 0);
        direct("pre_flush", 0, 3'b001, 0, 1);
        look(1, 10, 11, 12, 4);
        #1 chk("post_flush", 32'(sb_data), 32'd0);

        // Writes to r0 are dropped and r0 always reads the register file.
        cyc(1, 0, 2'b11, 2'b11, 2'b11, 5'd0, 5'd0, 0, 0, 0, 0);
        look(1, 0, 0, 0, 0); direct("r0", 0, 3'b000, 0, 0);

        // Asynchronous reset in the middle of traffic.
        cyc(1, 0, 2'b11, 2'b11, 2'b01, 5'd20, 5'd21, 0, 0, 0, 0);
        look(1, 20, 21, 0, 0); direct("pre_rst", 0, 3'b100, 0, 1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        model_clear();
        #1 chk("async_rst_data", 32'(sb_data), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        cyc(1, 0, 2'b11, 2'b11, 2'b11, 5'd22, 5'd23, 20, 21, 22, 23);
        #1 rst_n = 1'b1;
        look(1, 20, 21, 22, 23);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit [4:0] d0, d1, s [4];
            d0 = (($urandom % 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            d1 = (($urandom % 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            for (int k = 0; k < 4; k++)
                s[k] = (($urandom % 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            cyc(($urandom % 4) != 0, ($urandom % 30) == 0, 2'($urandom), 2'($urandom),
                2'($urandom), d0, d1, s[0], s[1], s[2], s[3]);
        end

        @(negedge clk); #1;
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
